// File: rtl/qdec_pkg.sv
`default_nettype none
// ============================================================================
// qdec_pkg : decode-mode constants, phase-state encodings and the quadrature
//            transition classifier shared by quad_step_decoder.
// Revision : 1.0
// ============================================================================
package qdec_pkg;

  localparam int MODE_X1 = 1;
  localparam int MODE_X2 = 2;
  localparam int MODE_X4 = 4;

  // Phase states are {A, B}
  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;

  typedef struct packed {
    logic valid;
    logic dir;
    logic illegal;
  } qdec_dec_t;

  // dir = 1 for the A-leads-B order 00->10->11->01->00
  function automatic qdec_dec_t qdec_dir(input logic [1:0] prev, input logic [1:0] cur);
    qdec_dec_t r;
    r = '0;
    case ({prev, cur})
      {S00, S10}, {S10, S11}, {S11, S01}, {S01, S00}: begin
        r.valid = 1'b1;
        r.dir   = 1'b1;
      end
      {S00, S01}, {S01, S11}, {S11, S10}, {S10, S00}: begin
        r.valid = 1'b1;
        r.dir   = 1'b0;
      end
      {S00, S11}, {S11, S00}, {S10, S01}, {S01, S10}: r.illegal = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Only meaningful for a valid transition; x1 counts the 00<->10 edges only
  function automatic logic qdec_qualify(input int mode, input logic [1:0] prev,
                                        input logic [1:0] cur);
    logic a_chg;
    a_chg = prev[1] ^ cur[1];
    case (mode)
      MODE_X1: return a_chg & ~cur[0];
      MODE_X2: return a_chg;
      default: return 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/qdec_filter.sv
`default_nettype none
// ============================================================================
// qdec_filter : per-channel synchroniser followed by a stable-count glitch
//               filter; also reports when the channel is quiescent.
// Revision    : 1.0
// ============================================================================
module qdec_filter
  import qdec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_filt,
  output logic o_settled
);

  localparam int CNT_W = $clog2(FILT_LEN) + 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] prime_q, prime_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   w_sync_x;

  assign w_sync_x = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], i_din};
    prime_d = {prime_q[SYNC_STAGES-2:0], 1'b1};
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    if (w_sync_x == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == C_CNT_LAST) begin
      filt_d = w_sync_x;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      prime_q <= '0;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prime_q <= prime_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
    end
  end

  // The reset zeros in the chain are not pin samples, so the channel only
  // counts as settled once the chain has been refilled from the pin.
  assign o_settled = prime_q[SYNC_STAGES-1] & (w_sync_x == filt_q);
  assign o_filt    = filt_q;

endmodule
`default_nettype wire

// File: rtl/quad_step_decoder.sv
`default_nettype none
// ============================================================================
// quad_step_decoder : quadrature front end producing a count-enable pulse,
//                     a held direction level and illegal-transition flags.
// Revision          : 1.0
// ============================================================================
module quad_step_decoder
  import qdec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int MODE        = MODE_X4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  input  logic clr_err,
  output logic step,
  output logic ud,
  output logic err,
  output logic err_flag
);

  logic [1:0] w_raw_ab, w_filt_ab, w_settled_ab;
  qdec_dec_t  w_dec;

  logic [1:0] prev_q, prev_d;
  logic       armed_q, armed_d;
  logic       step_q, step_d;
  logic       ud_q, ud_d;
  logic       err_q, err_d;
  logic       err_flag_q, err_flag_d;

  assign w_raw_ab = {a_in, b_in};

  for (genvar i = 0; i < 2; i++) begin : g_chan
    qdec_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN)
    ) u_filter (
      .clk      (clk),
      .rst      (rst),
      .i_din    (w_raw_ab[i]),
      .o_filt   (w_filt_ab[i]),
      .o_settled(w_settled_ab[i])
    );
  end

  assign w_dec = qdec_dir(prev_q, w_filt_ab);

  always_comb begin
    armed_d    = armed_q;
    prev_d     = prev_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    ud_d       = ud_q;
    err_flag_d = err_flag_q;
    if (!armed_q) begin
      if (&w_settled_ab) begin
        armed_d = 1'b1;
        prev_d  = w_filt_ab;
      end
    end else begin
      prev_d = w_filt_ab;
      if (w_dec.valid) begin
        ud_d   = w_dec.dir;
        step_d = qdec_qualify(MODE, prev_q, w_filt_ab);
      end else if (w_dec.illegal) begin
        err_d = 1'b1;
      end
    end
    // A fresh error outranks a simultaneous clear
    if (clr_err) err_flag_d = 1'b0;
    if (err_d)   err_flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= S00;
      armed_q    <= 1'b0;
      step_q     <= 1'b0;
      ud_q       <= 1'b1;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      armed_q    <= armed_d;
      step_q     <= step_d;
      ud_q       <= ud_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign step     = step_q;
  assign ud       = ud_q;
  assign err      = err_q;
  assign err_flag = err_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
// ============================================================================
// tb_quad_step_decoder : three decoders (x4, x2, x1) share one pin stimulus.
// Revision             : 1.0
// ============================================================================
module tb_quad_step_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 4;
  localparam int LAT         = SYNC_STAGES + FILT_LEN + 1;
  localparam int HOLD        = 12;
  localparam int NVEC        = 14;

  typedef struct {
    logic [1:0] ab;
    int         s4, s2, s1;
    logic       ud;
    int         err;
  } vec_t;

  logic clk = 1'b0;
  logic rst, a_in, b_in, clr_err;
  logic [2:0] step_v, ud_v, err_v, flag_v;
  logic [2:0] step_prev = 3'b000;

  int    checks   = 0;
  int    failures = 0;
  int    step_cnt [3] = '{0, 0, 0};
  int    err_cnt  [3] = '{0, 0, 0};
  int    s0 [3];
  int    e0 [3];
  int    exp_s [3];
  int    exp_e, lat, kind, h, len;
  logic  mud;
  logic [1:0] ms, nxt, bit_sel;
  vec_t  vecs [NVEC];
  string mname [3] = '{"x4", "x2", "x1"};

  always #5 clk = ~clk;

  quad_step_decoder #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .MODE(4)) u_dut_x4 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .clr_err(clr_err),
    .step(step_v[0]), .ud(ud_v[0]), .err(err_v[0]), .err_flag(flag_v[0]));
  quad_step_decoder #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .MODE(2)) u_dut_x2 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .clr_err(clr_err),
    .step(step_v[1]), .ud(ud_v[1]), .err(err_v[1]), .err_flag(flag_v[1]));
  quad_step_decoder #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .MODE(1)) u_dut_x1 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .clr_err(clr_err),
    .step(step_v[2]), .ud(ud_v[2]), .err(err_v[2]), .err_flag(flag_v[2]));

  // Pulse counters; a step pulse may never follow another step directly
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (step_v[i] === 1'b1) begin
        step_cnt[i]++;
        checks++;
        if (step_prev[i] === 1'b1) begin
          failures++;
          $display("FAIL step_back_to_back_%s actual=1 required=0", mname[i]);
        end
      end
      if (err_v[i] === 1'b1) err_cnt[i]++;
    end
    step_prev = step_v;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s0 = step_cnt;
    e0 = err_cnt;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_step_%s", tag, mname[i]), step_v[i], 0);
      check($sformatf("%s_err_%s", tag, mname[i]), err_v[i], 0);
      check($sformatf("%s_flag_%s", tag, mname[i]), flag_v[i], 0);
      check($sformatf("%s_ud_%s", tag, mname[i]), ud_v[i], 1);
    end
  endtask

  // Position around the Gray cycle, counting in the A-leads-B direction
  function automatic int pos_of(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_move(input logic [1:0] from, input logic [1:0] to);
    int pf, pt, d;
    pf = pos_of(from);
    pt = pos_of(to);
    d  = (pt - pf + 4) % 4;
    if (d == 1 || d == 3) begin
      mud = (d == 1);
      exp_s[0]++;
      if (pf / 2 == pt / 2) exp_s[1]++;
      if (pf + pt == 1)     exp_s[2]++;
    end else if (d == 2) begin
      exp_e++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{2'b10, 1, 1, 1, 1'b1, 0};
    vecs[1]  = '{2'b11, 1, 0, 0, 1'b1, 0};
    vecs[2]  = '{2'b01, 1, 1, 0, 1'b1, 0};
    vecs[3]  = '{2'b00, 1, 0, 0, 1'b1, 0};
    vecs[4]  = '{2'b01, 1, 0, 0, 1'b0, 0};
    vecs[5]  = '{2'b11, 1, 1, 0, 1'b0, 0};
    vecs[6]  = '{2'b10, 1, 0, 0, 1'b0, 0};
    vecs[7]  = '{2'b00, 1, 1, 1, 1'b0, 0};
    vecs[8]  = '{2'b10, 1, 1, 1, 1'b1, 0};
    vecs[9]  = '{2'b00, 1, 1, 1, 1'b0, 0};
    vecs[10] = '{2'b11, 0, 0, 0, 1'b0, 1};
    vecs[11] = '{2'b00, 0, 0, 0, 1'b0, 1};
    vecs[12] = '{2'b10, 1, 1, 1, 1'b1, 0};
    vecs[13] = '{2'b00, 1, 1, 1, 1'b0, 0};

    // Reset with both pins high, then idle: no false error from the 00 reset state
    rst = 1'b1; a_in = 1'b1; b_in = 1'b1; clr_err = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    snap();
    tick(60);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("idle11_steps_%s", mname[i]), step_cnt[i] - s0[i], 0);
      check($sformatf("idle11_errs_%s", mname[i]), err_cnt[i] - e0[i], 0);
    end
    check("idle11_ud", ud_v[0], 1);
    check("idle11_flag", flag_v[0], 0);

    rst = 1'b1; {a_in, b_in} = 2'b00;
    tick(2);
    rst = 1'b0;
    tick(20);

    // First-step latency from a single A edge
    snap();
    a_in = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (lat == 0 && step_v[0] === 1'b1) lat = k;
    end
    check("latency_edges", lat, LAT);
    check("latency_ud", ud_v[0], 1);
    a_in = 1'b0;
    tick(HOLD);
    check("return_ud", ud_v[0], 0);
    check("return_steps_x4", step_cnt[0] - s0[0], 2);

    for (int i = 0; i < NVEC; i++) begin
      snap();
      {a_in, b_in} = vecs[i].ab;
      tick(HOLD);
      check($sformatf("vec%0d_steps_x4", i), step_cnt[0] - s0[0], vecs[i].s4);
      check($sformatf("vec%0d_steps_x2", i), step_cnt[1] - s0[1], vecs[i].s2);
      check($sformatf("vec%0d_steps_x1", i), step_cnt[2] - s0[2], vecs[i].s1);
      check($sformatf("vec%0d_ud_x4", i), ud_v[0], vecs[i].ud);
      check($sformatf("vec%0d_ud_x1", i), ud_v[2], vecs[i].ud);
      check($sformatf("vec%0d_errs", i), err_cnt[0] - e0[0], vecs[i].err);
    end

    // Short pulse is swallowed; a FILT_LEN pulse gives an up then a down step
    snap();
    a_in = 1'b1;
    tick(FILT_LEN - 1);
    a_in = 1'b0;
    tick(HOLD);
    check("glitch_short_steps_x4", step_cnt[0] - s0[0], 0);
    check("glitch_short_ud", ud_v[0], 0);
    snap();
    a_in = 1'b1;
    tick(FILT_LEN);
    a_in = 1'b0;
    tick(LAT - FILT_LEN);
    check("glitch_long_first_step", step_v[0], 1);
    check("glitch_long_first_ud", ud_v[0], 1);
    tick(HOLD);
    check("glitch_long_steps_x4", step_cnt[0] - s0[0], 2);
    check("glitch_long_steps_x1", step_cnt[2] - s0[2], 2);
    check("glitch_long_ud", ud_v[0], 0);

    // Illegal jumps, flag clear, and set beating a coincident clear
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("preclear_flag", flag_v[0], 0);
    snap();
    {a_in, b_in} = 2'b11;
    tick(HOLD);
    check("illegal_errs", err_cnt[0] - e0[0], 1);
    check("illegal_flag", flag_v[0], 1);
    check("illegal_steps_x4", step_cnt[0] - s0[0], 0);
    check("illegal_ud", ud_v[0], 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clear_flag", flag_v[0], 0);
    snap();
    {a_in, b_in} = 2'b00;
    tick(LAT - 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("coincident_err_pulse", err_v[0], 1);
    check("coincident_flag_x4", flag_v[0], 1);
    check("coincident_flag_x1", flag_v[2], 1);
    tick(HOLD);
    check("coincident_errs", err_cnt[0] - e0[0], 1);

    // Reset in the middle of a filter count
    {a_in, b_in} = 2'b10;
    tick(4);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("midreset");
    tick(1);
    rst = 1'b0;
    snap();
    tick(20);
    check("post_reset_steps_x4", step_cnt[0] - s0[0], 0);
    check("post_reset_steps_x1", step_cnt[2] - s0[2], 0);
    check("post_reset_errs", err_cnt[0] - e0[0], 0);
    {a_in, b_in} = 2'b00;
    tick(HOLD);
    check("post_reset_move_steps", step_cnt[0] - s0[0], 1);
    check("post_reset_move_ud", ud_v[0], 0);

    // Random walk with glitches and illegal jumps against the position model
    rst = 1'b1; {a_in, b_in} = 2'b00;
    tick(2);
    rst = 1'b0;
    tick(20);
    snap();
    ms = 2'b00; mud = 1'b1; exp_s = '{0, 0, 0}; exp_e = 0;
    for (int n = 0; n < 200; n++) begin
      kind    = int'($urandom_range(0, 9));
      h       = FILT_LEN + int'($urandom_range(0, 3));
      bit_sel = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
      if (kind < 7) begin
        nxt = ms ^ bit_sel;
        model_move(ms, nxt);
        ms = nxt;
        {a_in, b_in} = ms;
        tick(h);
      end else if (kind < 8) begin
        nxt = ms ^ 2'b11;
        model_move(ms, nxt);
        ms = nxt;
        {a_in, b_in} = ms;
        tick(h);
      end else begin
        len = int'($urandom_range(1, FILT_LEN - 1));
        {a_in, b_in} = ms ^ bit_sel;
        tick(len);
        {a_in, b_in} = ms;
        tick(h);
      end
    end
    tick(20);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rand_steps_%s", mname[i]), step_cnt[i] - s0[i], exp_s[i]);
      check($sformatf("rand_ud_%s", mname[i]), ud_v[i], mud);
      check($sformatf("rand_errs_%s", mname[i]), err_cnt[i] - e0[i], exp_e);
      check($sformatf("rand_flag_%s", mname[i]), flag_v[i], (exp_e > 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
